bp_trace_capture: RTL
=====================

Name: bp_trace_capture

Overview:
Consumes the per-statement trace events emitted by instrumented design modules (one statement ID per executed statement). Matches each event against a programmable breakpoint table and captures hits with a timestamp into a FIFO. On a hit it halts the trace stream until the debug host resumes. It sits directly downstream of the instrumented logic and upstream of the debug host interface.

Parameters:
STMT_W, 32, width of statement ID
NUM_BP, 8, breakpoint table entries (power of 2, >=2)
DEPTH, 16, capture FIFO depth (power of 2, >=2)
TS_W, 32, timestamp counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
trace_valid  input  1  statement event present
trace_stmt_id  input  STMT_W  executed statement ID
trace_ready  output  1  event accepted this cycle when valid&ready
step_mode  input  1  every accepted event is treated as a hit
cfg_we  input  1  breakpoint table write strobe
cfg_idx  input  $clog2(NUM_BP)  table entry index
cfg_stmt_id  input  STMT_W  ID written to entry
cfg_en  input  1  enable bit written to entry
resume  input  1  single-cycle pulse: leave HALT
out_valid  output  1  capture FIFO non-empty
out_ready  input  1  host pops head when valid&ready
out_stmt_id  output  STMT_W  head entry ID
out_ts  output  TS_W  head entry timestamp
halt  output  1  state is HALT
overflow  output  1  sticky: hit dropped because FIFO full
ovf_clr  input  1  clears overflow

Behaviour:
- Reset (async, rst_n=0): state RUN; table entries all disabled, IDs 0; FIFO empty; ts=0; out_valid=0, halt=0, overflow=0, trace_ready=1; out_stmt_id/out_ts read 0.
- ts: free-running, +1 every cycle, wraps 2^TS_W-1 -> 0.
- trace_ready = (state==RUN), combinational from the state register.
- Accept = trace_valid & trace_ready. Hit = accept & (step_mode | any entry with en=1 and id==trace_stmt_id). Comparison is fully parallel in one cycle.
- On hit: push {trace_stmt_id, ts of that cycle}. State goes RUN->HALT at the next edge, so halt=1 and trace_ready=0 from the following cycle. out_valid rises the cycle after the push (one-cycle latency).
- Non-hit accepted events are consumed silently. FIFO and state are unchanged.
- HALT: no events accepted. A resume pulse moves HALT->RUN at the next edge. resume is ignored in RUN. halt and FIFO contents are independent; the host may drain before or after resume.
- Hit while FIFO full and no pop in the same cycle: entry dropped, overflow set (sticky), state still goes to HALT.
- Full with a simultaneous pop: push succeeds, no overflow.
- Empty: a push and a pop cannot happen together (out_valid=0).
- ovf_clr clears overflow. If ovf_clr and a new overflow occur in the same cycle, set wins.
- Config: a cfg_we write updates entry cfg_idx at the edge. A compare in the same cycle uses the old table contents. Writes are legal in any state.
- Duplicate enabled IDs in the table: a single hit, a single push.
- FIFO: head registered. Pointers carry an extra wrap bit for full/empty. Pop order is FIFO.
- Mid-operation reset: all state is lost immediately, as specified for reset.

Decomposition:
- Package bp_trace_pkg:
  - typedef bp_entry_t {logic en; logic [STMT_W-1:0] id}
  - typedef cap_entry_t {stmt_id, ts}
  - enum state_t {RUN, HALT}
  - default width constants
- Sub-module bp_trace_fifo: parameterised sync FIFO of cap_entry_t with push/pop/full/empty.
- Table, matcher, FSM, counter and overflow logic live in the top.

Test Plan:
- Table entry 2 = {en=1, id=0x3}. Stream IDs 0x0,0x2,0x3,0x4 back-to-back -> one capture {0x3, ts at accept}. halt=1 the next cycle. trace_ready=0, so 0x4 is held until resume. After resume, 0x4 is accepted with no capture.
- step_mode=1, empty table. Send IDs 0x0..0x5, pulsing resume after each halt and popping each capture -> six captures in order with strictly increasing ts. overflow stays 0.
- DEPTH=16, step_mode=1, no pops. Generate 17 hits with resume between them -> 16 entries held, overflow=1 after the 17th. ovf_clr -> overflow=0. Draining yields the first 16 IDs.
- cfg_we writes entry 0 = {1, 0x5} in the same cycle ID 0x5 arrives -> no hit. The next 0x5 hits.
- FIFO full, then a hit with out_ready=1 in the same cycle -> push succeeds, overflow stays 0, count stays 16.
- Assert rst_n=0 mid-HALT with 3 entries queued -> immediately halt=0, out_valid=0, trace_ready=1. After release, table entries are disabled: ID 0x3 produces no hit.

Source files
------------

// File: rtl/bp_trace_pkg.sv
// Shared types and default widths for the breakpoint trace capture block.
package bp_trace_pkg;

  localparam int STMT_W_DEF = 32;
  localparam int NUM_BP_DEF = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int TS_W_DEF   = 32;

  // Breakpoint table row at the default statement-ID width.
  typedef struct packed {
    logic                  en;
    logic [STMT_W_DEF-1:0] id;
  } bp_entry_t;

  // Captured hit at the default widths: statement ID plus timestamp.
  typedef struct packed {
    logic [STMT_W_DEF-1:0] stmt_id;
    logic [TS_W_DEF-1:0]   ts;
  } cap_entry_t;

  // Trace stream state: RUN accepts events, HALT stalls until resume.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/bp_trace_fifo.sv
// Synchronous capture FIFO with a registered head entry.
// The pointers carry an extra wrap bit so full and empty can be told apart.
// A push while full is accepted only if a pop happens in the same cycle.
module bp_trace_fifo
  import bp_trace_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = cap_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  T             head_reg;
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic [AW-1:0] rd_nidx;
  logic         pop_ok;
  logic         push_ok;
  logic         count_one;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign count_one = ((wr_ptr_reg - rd_ptr_reg) == (AW+1)'(1));
  assign rd_nidx   = rd_ptr_reg[AW-1:0] + AW'(1);
  assign head      = head_reg;

  // Storage array; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Pointer advance and head register refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      if (pop_ok) begin
        // Popping the last stored entry: the only candidate for the new head
        // is the entry being pushed in this same cycle.
        if (count_one) begin
          if (push_ok) head_reg <= push_data;
        end else begin
          head_reg <= mem[rd_nidx];
        end
      end else if (push_ok && empty) begin
        head_reg <= push_data;
      end
    end
  end

endmodule

// File: rtl/bp_trace_capture.sv
// Breakpoint matcher for instrumented statement trace events.
// Accepted events are compared against a programmable table in parallel;
// hits are captured with a timestamp and stall the stream until resume.
module bp_trace_capture
  import bp_trace_pkg::*;
#(
  parameter int STMT_W = STMT_W_DEF,
  parameter int NUM_BP = NUM_BP_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TS_W   = TS_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trace_valid,
  input  logic [STMT_W-1:0]         trace_stmt_id,
  output logic                      trace_ready,
  input  logic                      step_mode,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_BP)-1:0] cfg_idx,
  input  logic [STMT_W-1:0]         cfg_stmt_id,
  input  logic                      cfg_en,
  input  logic                      resume,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [STMT_W-1:0]         out_stmt_id,
  output logic [TS_W-1:0]           out_ts,
  output logic                      halt,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int IDX_W = $clog2(NUM_BP);

  // Package types fix the default widths; these follow the actual parameters.
  typedef struct packed {
    logic              en;
    logic [STMT_W-1:0] id;
  } bp_row_t;

  typedef struct packed {
    logic [STMT_W-1:0] stmt_id;
    logic [TS_W-1:0]   ts;
  } cap_t;

  state_t            state_reg;
  logic [TS_W-1:0]   ts_reg;
  logic              overflow_reg;
  logic [NUM_BP-1:0] match_vec;
  logic              accept;
  logic              hit;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  cap_t              cap_in;
  cap_t              cap_head;

  // Breakpoint table: one row per generate slice, compared in parallel.
  // A write lands at the edge, so a same-cycle compare sees the old row.
  genvar gi;
  for (gi = 0; gi < NUM_BP; gi++) begin : g_bp
    bp_row_t entry_reg;

    // Row update from the configuration port.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_reg <= '0;
      end else if (cfg_we && (cfg_idx == IDX_W'(gi))) begin
        entry_reg.en <= cfg_en;
        entry_reg.id <= cfg_stmt_id;
      end
    end

    assign match_vec[gi] = entry_reg.en && (entry_reg.id == trace_stmt_id);
  end

  assign trace_ready = (state_reg == RUN);
  assign halt        = (state_reg == HALT);
  assign accept      = trace_valid && trace_ready;
  // Duplicate matching rows collapse into a single hit.
  assign hit         = accept && (step_mode || (|match_vec));
  assign pop         = out_valid && out_ready;
  assign out_valid   = !fifo_empty;
  assign overflow    = overflow_reg;
  assign out_stmt_id = cap_head.stmt_id;
  assign out_ts      = cap_head.ts;

  always_comb begin
    cap_in         = '0;
    cap_in.stmt_id = trace_stmt_id;
    cap_in.ts      = ts_reg;
  end

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_reg <= '0;
    else        ts_reg <= ts_reg + TS_W'(1);
  end

  // Stream state: a hit halts, a resume pulse releases; resume in RUN is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      case (state_reg)
        RUN:     if (hit)    state_reg <= HALT;
        HALT:    if (resume) state_reg <= RUN;
        default: state_reg <= RUN;
      endcase
    end
  end

  // Sticky overflow: a dropped hit sets it, and setting beats clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           overflow_reg <= 1'b0;
    else if (hit && fifo_full && !pop)    overflow_reg <= 1'b1;
    else if (ovf_clr)                     overflow_reg <= 1'b0;
  end

  bp_trace_fifo #(
    .DEPTH (DEPTH),
    .T     (cap_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (hit),
    .push_data (cap_in),
    .pop       (out_ready),
    .head      (cap_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
